bcd_display_formatter: RTL and testbench

BCD_DISPLAY_FORMATTER -- requirements
Module: bcd_display_formatter

---
 rtl/bcd_display_formatter_pkg.sv | 29 ++
 rtl/bcd_display_formatter_if.sv | 24 ++
 rtl/bcd_display_formatter_add3.sv | 7 +
 rtl/bcd_display_formatter.sv | 144 ++++++++++++++
 tb/tb_bcd_display_formatter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_display_formatter_pkg.sv
// Shared types and constants for the BCD/hex display formatter.
package bcd_display_formatter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      FIN  = 2'd2
   } state_t;

   localparam logic [31:0] DEC_MAX    = 32'd99_999_999;
   localparam logic [31:0] SAT_DIGITS = 32'h9999_9999;
   localparam logic [7:0]  EN_RESET   = 8'hFE;

   // Active-low enables with every digit above the most significant nonzero
   // digit switched off; digit 0 always stays lit.
   function automatic logic [7:0] blank_en(input logic [31:0] bcd);
      logic [7:0] en;
      logic       seen;
      en   = 8'h00;
      seen = 1'b0;
      for (int k = 7; k >= 0; k--) begin
         if (bcd[4*k +: 4] != 4'h0) seen = 1'b1;
         en[k] = ~seen;
      end
      en[0] = 1'b0;
      return en;
   endfunction

endpackage

// File: rtl/bcd_display_formatter_if.sv
// Request/result bundle between a requester and the display formatter.
interface bcd_display_formatter_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             hexmode;
   logic             blank;
   logic [WIDTH-1:0] value;
   logic [31:0]      digits;
   logic [7:0]       en;
   logic             busy;
   logic             done;
   logic             ovf;

   modport master (
      output start, hexmode, blank, value,
      input  digits, en, busy, done, ovf
   );

   modport slave (
      input  start, hexmode, blank, value,
      output digits, en, busy, done, ovf
   );
endinterface

// File: rtl/bcd_display_formatter_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more.
module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);
   assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/bcd_display_formatter.sv
// Formats a binary value for an 8-digit seven-segment display, either as
// hex nibbles or as decimal BCD digits (double-dabble), with optional
// leading-zero blanking and decimal overflow saturation.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last result
// CONV  | double-dabble, one shift per cycle, WIDTH iterations
// FIN   | write digits/en/ovf, pulse done next cycle, release busy
module bcd_display_formatter
   import bcd_display_formatter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic                    clk,
   input logic                    reset,
   bcd_display_formatter_if.slave bus
);

   localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] shift_q,  shift_d;
   logic [31:0]      bcd_q,    bcd_d;
   logic             hex_q,    hex_d;
   logic             blank_q,  blank_d;
   logic             sat_q,    sat_d;
   logic [31:0]      digits_q, digits_d;
   logic [7:0]       en_q,     en_d;
   logic             ovf_q,    ovf_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   logic [31:0]         bcd_adj;
   logic [WIDTH+31:0]   dd_shifted;
   logic [31:0]         result;

   for (genvar g = 0; g < 8; g++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (bcd_q[4*g +: 4]),
         .dout (bcd_adj[4*g +: 4])
      );
   end

   // Corrected BCD and binary shift as one register pair, and the final word.
   always_comb begin
      dd_shifted = {bcd_adj, shift_q} << 1;
      result     = hex_q ? 32'(shift_q) : bcd_q;
   end

   // Next-state and output logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      bcd_d    = bcd_q;
      hex_d    = hex_q;
      blank_d  = blank_q;
      sat_d    = sat_q;
      digits_d = digits_q;
      en_d     = en_q;
      ovf_d    = ovf_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               shift_d = bus.value;
               bcd_d   = '0;
               cnt_d   = '0;
               hex_d   = bus.hexmode;
               blank_d = bus.blank;
               sat_d   = !bus.hexmode && (64'(bus.value) > 64'(DEC_MAX));
               busy_d  = 1'b1;
               state_d = (bus.hexmode || sat_d) ? FIN : CONV;
            end
         end
         CONV: begin
            bcd_d   = dd_shifted[WIDTH+31:WIDTH];
            shift_d = dd_shifted[WIDTH-1:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = FIN;
            end
         end
         FIN: begin
            if (sat_q) begin
               digits_d = SAT_DIGITS;
               en_d     = 8'h00;
               ovf_d    = 1'b1;
            end else begin
               digits_d = result;
               en_d     = blank_q ? blank_en(result) : 8'h00;
               ovf_d    = 1'b0;
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers; reset aborts any conversion in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shift_q  <= '0;
         bcd_q    <= '0;
         hex_q    <= 1'b0;
         blank_q  <= 1'b0;
         sat_q    <= 1'b0;
         digits_q <= '0;
         en_q     <= EN_RESET;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         bcd_q    <= bcd_d;
         hex_q    <= hex_d;
         blank_q  <= blank_d;
         sat_q    <= sat_d;
         digits_q <= digits_d;
         en_q     <= en_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.digits = digits_q;
   assign bus.en     = en_q;
   assign bus.ovf    = ovf_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Bench for bcd_display_formatter: directed cases, back-to-back, randomized
// requests against a decimal/hex reference model, and reset abort.
module tb_bcd_display_formatter;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   bcd_display_formatter_if #(.WIDTH(32)) bus ();

   bcd_display_formatter #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: plain decimal arithmetic.
   function automatic logic [31:0] m_digits(input bit hm, input logic [31:0] v);
      logic [31:0] r;
      logic [31:0] t;
      if (hm) return v;
      if (v > 32'd99_999_999) return 32'h9999_9999;
      r = '0;
      t = v;
      for (int k = 0; k < 8; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [7:0] m_en(input bit hm, input bit bl, input logic [31:0] v);
      logic [31:0] dg;
      logic [7:0]  r;
      int          top;
      if (!hm && v > 32'd99_999_999) return 8'h00;
      if (!bl) return 8'h00;
      dg  = m_digits(hm, v);
      top = 0;
      for (int k = 0; k < 8; k++) if (dg[4*k +: 4] != 4'h0) top = k;
      r = 8'h00;
      for (int k = 0; k < 8; k++) if (k > top) r[k] = 1'b1;
      return r;
   endfunction

   function automatic int m_lat(input bit hm, input logic [31:0] v);
      return (hm || v > 32'd99_999_999) ? 1 : 33;
   endfunction

   // Issues one request starting at a negedge; returns edges from accept to
   // result write, the result, and a count of busy/hold violations.
   task automatic run_op(input bit hm, input bit bl, input logic [31:0] v, input bit noise,
                         output int lat, output logic [31:0] d, output logic [7:0] e,
                         output logic o, output int glitch);
      logic [31:0] d0;
      logic [7:0]  e0;
      logic        o0;
      d0 = '0; e0 = '0; o0 = 1'b0;
      bus.start = 1'b1; bus.hexmode = hm; bus.blank = bl; bus.value = v;
      @(posedge clk);
      lat = 0; glitch = 0;
      while (lat < 40) begin
         @(negedge clk);
         if (lat == 0) begin d0 = bus.digits; e0 = bus.en; o0 = bus.ovf; end
         if (bus.done === 1'b1) break;
         if (bus.busy !== 1'b1 || bus.digits !== d0 || bus.en !== e0 || bus.ovf !== o0)
            glitch++;
         if (noise) begin
            bus.start   = 1'($urandom);
            bus.hexmode = 1'($urandom);
            bus.blank   = 1'($urandom);
            bus.value   = $urandom;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk);
         lat++;
      end
      if (bus.busy !== 1'b0) glitch++;
      d = bus.digits; e = bus.en; o = bus.ovf;
      bus.start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      #12;
      total++; if (bus.digits !== 32'h0) begin bad++; $display("FAIL reset digits got %h want 00000000", bus.digits); end
      total++; if (bus.en !== 8'hFE) begin bad++; $display("FAIL reset en got %h want fe", bus.en); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy got %b want 0", bus.busy); end
      total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset done got %b want 0", bus.done); end
      total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset ovf got %b want 0", bus.ovf); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      bit          hm;
      bit          bl;
      logic [31:0] v;
      int          lat;
      logic [31:0] d;
      logic [7:0]  e;
      logic        o;
   } dcase_t;

   task automatic test_directed;
      dcase_t      cs[8];
      int          lat, gl;
      logic [31:0] d;
      logic [7:0]  e;
      logic        o;
      cs[0] = '{0, 1, 32'd1234,        33, 32'h0000_1234, 8'hF0, 1'b0};
      cs[1] = '{1, 0, 32'hDEAD_BEEF,   1,  32'hDEAD_BEEF, 8'h00, 1'b0};
      cs[2] = '{0, 1, 32'd100_000_000, 1,  32'h9999_9999, 8'h00, 1'b1};
      cs[3] = '{0, 1, 32'd0,           33, 32'h0000_0000, 8'hFE, 1'b0};
      cs[4] = '{0, 0, 32'd99_999_999,  33, 32'h9999_9999, 8'h00, 1'b0};
      cs[5] = '{0, 1, 32'd99_999_999,  33, 32'h9999_9999, 8'h00, 1'b0};
      cs[6] = '{1, 1, 32'h0000_0A05,   1,  32'h0000_0A05, 8'hF8, 1'b0};
      cs[7] = '{0, 1, 32'd10,          33, 32'h0000_0010, 8'hFC, 1'b0};
      for (int i = 0; i < 8; i++) begin
         run_op(cs[i].hm, cs[i].bl, cs[i].v, 1'b0, lat, d, e, o, gl);
         total++; if (lat !== cs[i].lat) begin bad++; $display("FAIL dir%0d latency got %0d want %0d", i, lat, cs[i].lat); end
         total++; if (d !== cs[i].d) begin bad++; $display("FAIL dir%0d digits got %h want %h", i, d, cs[i].d); end
         total++; if (e !== cs[i].e) begin bad++; $display("FAIL dir%0d en got %h want %h", i, e, cs[i].e); end
         total++; if (o !== cs[i].o) begin bad++; $display("FAIL dir%0d ovf got %b want %b", i, o, cs[i].o); end
         total++; if (gl != 0) begin bad++; $display("FAIL dir%0d busy/hold violations got %0d want 0", i, gl); end
         @(negedge clk);
         total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL dir%0d done width got %b want 0", i, bus.done); end
      end
   endtask

   task automatic test_back_to_back;
      int          lat, gl;
      logic [31:0] d;
      logic [7:0]  e;
      logic        o;
      run_op(1'b0, 1'b1, 32'd4321, 1'b1, lat, d, e, o, gl);
      total++; if (d !== 32'h0000_4321) begin bad++; $display("FAIL b2b_a digits got %h want 00004321", d); end
      total++; if (lat !== 33 || gl != 0) begin bad++; $display("FAIL b2b_a latency/hold got %0d/%0d want 33/0", lat, gl); end
      total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b done before restart got %b want 1", bus.done); end
      run_op(1'b1, 1'b1, 32'h0000_0012, 1'b0, lat, d, e, o, gl);
      total++; if (lat !== 1 || gl != 0) begin bad++; $display("FAIL b2b_b latency/hold got %0d/%0d want 1/0", lat, gl); end
      total++; if (d !== 32'h0000_0012 || e !== 8'hFC) begin bad++; $display("FAIL b2b_b result got %h/%h want 00000012/fc", d, e); end
      run_op(1'b0, 1'b0, 32'd7, 1'b0, lat, d, e, o, gl);
      total++; if (lat !== 33 || gl != 0) begin bad++; $display("FAIL b2b_c latency/hold got %0d/%0d want 33/0", lat, gl); end
      total++; if (d !== 32'h0000_0007 || e !== 8'h00) begin bad++; $display("FAIL b2b_c result got %h/%h want 00000007/00", d, e); end
      @(negedge clk);
   endtask

   task automatic test_random;
      int          lat, gl;
      logic [31:0] d, v;
      logic [7:0]  e;
      logic        o;
      bit          hm, bl, nz;
      for (int i = 0; i < 30; i++) begin
         hm = 1'($urandom);
         bl = 1'($urandom);
         nz = 1'($urandom);
         case ($urandom_range(0, 3))
            0: v = $urandom;
            1: v = $urandom_range(0, 99_999_999);
            2: v = $urandom_range(0, 999);
            default: v = 32'd99_999_995 + $urandom_range(0, 10);
         endcase
         run_op(hm, bl, v, nz, lat, d, e, o, gl);
         total++; if (lat !== m_lat(hm, v)) begin bad++; $display("FAIL rand%0d latency got %0d want %0d", i, lat, m_lat(hm, v)); end
         total++; if (d !== m_digits(hm, v)) begin bad++; $display("FAIL rand%0d digits got %h want %h (v=%0d hm=%b)", i, d, m_digits(hm, v), v, hm); end
         total++; if (e !== m_en(hm, bl, v)) begin bad++; $display("FAIL rand%0d en got %h want %h", i, e, m_en(hm, bl, v)); end
         total++; if (o !== (!hm && v > 32'd99_999_999)) begin bad++; $display("FAIL rand%0d ovf got %b want %b", i, o, (!hm && v > 32'd99_999_999)); end
         total++; if (gl != 0) begin bad++; $display("FAIL rand%0d busy/hold violations got %0d want 0", i, gl); end
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
   endtask

   task automatic test_reset_abort;
      int          lat, gl, seen;
      logic [31:0] d;
      logic [7:0]  e;
      logic        o;
      run_op(1'b1, 1'b0, 32'hCAFE_F00D, 1'b0, lat, d, e, o, gl);
      @(negedge clk);
      bus.start = 1'b1; bus.hexmode = 1'b0; bus.blank = 1'b1; bus.value = 32'd54321;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (bus.digits !== 32'h0 || bus.en !== 8'hFE) begin bad++; $display("FAIL abort outputs got %h/%h want 00000000/fe", bus.digits, bus.en); end
      total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ovf !== 1'b0) begin bad++; $display("FAIL abort flags got busy=%b done=%b ovf=%b want 0/0/0", bus.busy, bus.done, bus.ovf); end
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      end
      total++; if (seen != 0) begin bad++; $display("FAIL abort stray done/busy cycles got %0d want 0", seen); end
      run_op(1'b0, 1'b1, 32'd807, 1'b0, lat, d, e, o, gl);
      total++; if (lat !== 33 || gl != 0) begin bad++; $display("FAIL restart latency/hold got %0d/%0d want 33/0", lat, gl); end
      total++; if (d !== 32'h0000_0807 || e !== 8'hF8 || o !== 1'b0) begin bad++; $display("FAIL restart result got %h/%h/%b want 00000807/f8/0", d, e, o); end
      @(negedge clk);
   endtask

   initial begin
      reset       = 1'b1;
      bus.start   = 1'b0;
      bus.hexmode = 1'b0;
      bus.blank   = 1'b0;
      bus.value   = '0;
      test_reset;
      test_directed;
      test_back_to_back;
      test_random;
      test_reset_abort;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
